// File: rtl/pipe_pkg.sv
// Shared definitions for handshaked pipeline stage registers.
package pipe_pkg;

  // Stage occupancy states; encoding equals the number of entries held.
  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_BUSY  = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_state_e;

  // Exception code meaning "no exception".
  localparam int unsigned EXC_NONE  = 0;

  // Width of the RegsWrType register-write enable vector.
  localparam int unsigned REGS_WR_W = 3;

  // Number of entries held in a given state.
  function automatic logic [1:0] state_occupancy(input pipe_state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      PIPE_EMPTY: occ = 2'd0;
      PIPE_BUSY:  occ = 2'd1;
      PIPE_FULL:  occ = 2'd2;
      default:    occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating up-counter with enable; counts back-pressure cycles.
module pipe_stall_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Increment while enabled, sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline stage register with flush, exception write-kill and
// stall counter. Define PIPE_SKID_BUFFER_EN for the two-entry skid-buffer
// variant with registered in_ready; otherwise a single entry is held.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned EXC_W     = 5,
  parameter int unsigned WREN_W    = REGS_WR_W,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [EXC_W-1:0]     in_exc,
  input  logic [WREN_W-1:0]    in_wren,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [EXC_W-1:0]     out_exc,
  output logic [WREN_W-1:0]    out_wren,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  pipe_state_e          state_q, state_d;
  logic [PAYLOAD_W-1:0] main_pl_q, main_pl_d;
  logic [EXC_W-1:0]     main_exc_q, main_exc_d;
  logic [WREN_W-1:0]    main_wren_q, main_wren_d;

  logic                 in_xfer;
  logic                 out_xfer;
  logic [WREN_W-1:0]    cap_wren;

  assign out_valid   = (state_q != PIPE_EMPTY);
  assign out_xfer    = out_valid && out_ready;
  assign in_xfer     = in_valid && in_ready && !flush;
  assign cap_wren    = (in_exc != EXC_W'(EXC_NONE)) ? '0 : in_wren;
  assign out_payload = main_pl_q;
  assign out_exc     = main_exc_q;
  assign out_wren    = main_wren_q;
  assign occupancy   = state_occupancy(state_q);

`ifdef PIPE_SKID_BUFFER_EN
  logic [PAYLOAD_W-1:0] skid_pl_q, skid_pl_d;
  logic [EXC_W-1:0]     skid_exc_q, skid_exc_d;
  logic [WREN_W-1:0]    skid_wren_q, skid_wren_d;
  logic                 in_ready_q;

  // Registered ready; reset value 1 is masked while rst is held low.
  assign in_ready = in_ready_q && rst;

  // Next-state and entry movement for the two-entry skid buffer.
  always_comb begin
    state_d     = state_q;
    main_pl_d   = main_pl_q;
    main_exc_d  = main_exc_q;
    main_wren_d = main_wren_q;
    skid_pl_d   = skid_pl_q;
    skid_exc_d  = skid_exc_q;
    skid_wren_d = skid_wren_q;
    if (flush) begin
      state_d     = PIPE_EMPTY;
      main_pl_d   = '0;
      main_exc_d  = '0;
      main_wren_d = '0;
      skid_pl_d   = '0;
      skid_exc_d  = '0;
      skid_wren_d = '0;
    end else begin
      case (state_q)
        PIPE_EMPTY: begin
          if (in_xfer) begin
            main_pl_d   = in_payload;
            main_exc_d  = in_exc;
            main_wren_d = cap_wren;
            state_d     = PIPE_BUSY;
          end
        end
        PIPE_BUSY: begin
          if (in_xfer && out_xfer) begin
            main_pl_d   = in_payload;
            main_exc_d  = in_exc;
            main_wren_d = cap_wren;
          end else if (in_xfer) begin
            skid_pl_d   = in_payload;
            skid_exc_d  = in_exc;
            skid_wren_d = cap_wren;
            state_d     = PIPE_FULL;
          end else if (out_xfer) begin
            state_d = PIPE_EMPTY;
          end
        end
        PIPE_FULL: begin
          if (out_xfer) begin
            main_pl_d   = skid_pl_q;
            main_exc_d  = skid_exc_q;
            main_wren_d = skid_wren_q;
            state_d     = PIPE_BUSY;
          end
        end
        default: state_d = PIPE_EMPTY;
      endcase
    end
  end

  // State, entry and ready registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= PIPE_EMPTY;
      main_pl_q   <= '0;
      main_exc_q  <= '0;
      main_wren_q <= '0;
      skid_pl_q   <= '0;
      skid_exc_q  <= '0;
      skid_wren_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_pl_q   <= main_pl_d;
      main_exc_q  <= main_exc_d;
      main_wren_q <= main_wren_d;
      skid_pl_q   <= skid_pl_d;
      skid_exc_q  <= skid_exc_d;
      skid_wren_q <= skid_wren_d;
      in_ready_q  <= (state_d != PIPE_FULL);
    end
  end
`else
  // Single entry: accept when empty or when the held entry leaves this cycle.
  assign in_ready = rst && (!out_valid || out_ready);

  // Next-state and capture for the single-entry stage.
  always_comb begin
    state_d     = state_q;
    main_pl_d   = main_pl_q;
    main_exc_d  = main_exc_q;
    main_wren_d = main_wren_q;
    if (flush) begin
      state_d     = PIPE_EMPTY;
      main_pl_d   = '0;
      main_exc_d  = '0;
      main_wren_d = '0;
    end else begin
      case (state_q)
        PIPE_EMPTY: begin
          if (in_xfer) begin
            main_pl_d   = in_payload;
            main_exc_d  = in_exc;
            main_wren_d = cap_wren;
            state_d     = PIPE_BUSY;
          end
        end
        PIPE_BUSY: begin
          if (in_xfer) begin
            main_pl_d   = in_payload;
            main_exc_d  = in_exc;
            main_wren_d = cap_wren;
          end else if (out_xfer) begin
            state_d = PIPE_EMPTY;
          end
        end
        default: state_d = PIPE_EMPTY;
      endcase
    end
  end

  // State and entry registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= PIPE_EMPTY;
      main_pl_q   <= '0;
      main_exc_q  <= '0;
      main_wren_q <= '0;
    end else begin
      state_q     <= state_d;
      main_pl_q   <= main_pl_d;
      main_exc_q  <= main_exc_d;
      main_wren_q <= main_wren_d;
    end
  end
`endif

  pipe_stall_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk_i (clk),
    .rst_ni(rst),
    .en_i  (out_valid && !out_ready),
    .cnt_o (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed self-checking bench for pipe_stage_hs (either build variant).
module tb_pipe_stage_hs;

  localparam int unsigned PW = 16;
  localparam int unsigned EW = 5;
  localparam int unsigned WW = 3;
  localparam int unsigned CW = 4;
`ifdef PIPE_SKID_BUFFER_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_payload;
  logic [EW-1:0] in_exc;
  logic [WW-1:0] in_wren;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_payload;
  logic [EW-1:0] out_exc;
  logic [WW-1:0] out_wren;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_hs #(
    .PAYLOAD_W(PW),
    .EXC_W    (EW),
    .WREN_W   (WW),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_payload (in_payload),
    .in_exc     (in_exc),
    .in_wren    (in_wren),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload(out_payload),
    .out_exc    (out_exc),
    .out_wren   (out_wren),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [PW-1:0] pl,
                       input logic [EW-1:0] exc, input logic [WW-1:0] wren);
    in_valid   = v;
    in_payload = pl;
    in_exc     = exc;
    in_wren    = wren;
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_payload", 64'(out_payload), 64'd0);
    chk("rst_wren", 64'(out_wren), 64'd0);

    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // First capture, no exception.
    out_ready = 1'b1;
    drive(1'b1, 16'hA5A5, 5'd0, 3'b111);
    tick();
    chk("cap1_valid", 64'(out_valid), 64'd1);
    chk("cap1_wren", 64'(out_wren), 64'h7);
    chk("cap1_payload", 64'(out_payload), 64'hA5A5);
    chk("cap1_exc", 64'(out_exc), 64'd0);
    chk("cap1_occ", 64'(occupancy), 64'd1);

    // Back-to-back capture with exception: write-kill.
    drive(1'b1, 16'h1234, 5'd4, 3'b101);
    tick();
    chk("kill_wren", 64'(out_wren), 64'd0);
    chk("kill_exc", 64'(out_exc), 64'd4);
    chk("kill_payload", 64'(out_payload), 64'h1234);
    chk("kill_occ", 64'(occupancy), 64'd1);

    // Drain: fields hold, valid drops.
    drive(1'b0, 16'h0000, 5'd0, 3'b000);
    tick();
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_occ", 64'(occupancy), 64'd0);
    chk("drain_payload_hold", 64'(out_payload), 64'h1234);
    chk("drain_stall", 64'(stall_cnt), 64'd0);

    // Back-pressure: push A then B.
    out_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 5'd0, 3'b001);
    tick();
    chk("pushA_occ", 64'(occupancy), 64'd1);
    chk("pushA_payload", 64'(out_payload), 64'hAAAA);
    drive(1'b1, 16'hBBBB, 5'd0, 3'b010);
    tick();
    chk("pushB_occ", 64'(occupancy), SKID ? 64'd2 : 64'd1);
    chk("pushB_in_ready", 64'(in_ready), 64'd0);
    chk("pushB_head", 64'(out_payload), 64'hAAAA);
    chk("pushB_stall", 64'(stall_cnt), 64'd1);
    drive(1'b0, 16'h0000, 5'd0, 3'b000);
    tick();
    chk("hold_stall", 64'(stall_cnt), 64'd2);
    chk("hold_head", 64'(out_payload), 64'hAAAA);

    // Pop in FIFO order.
    out_ready = 1'b1;
    tick();
    chk("pop1_valid", 64'(out_valid), SKID ? 64'd1 : 64'd0);
    chk("pop1_payload", 64'(out_payload), SKID ? 64'hBBBB : 64'hAAAA);
    chk("pop1_wren", 64'(out_wren), SKID ? 64'h2 : 64'h1);
    chk("pop1_occ", 64'(occupancy), SKID ? 64'd1 : 64'd0);
    chk("pop1_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("pop2_valid", 64'(out_valid), 64'd0);
    chk("pop2_occ", 64'(occupancy), 64'd0);
    chk("pop2_stall", 64'(stall_cnt), 64'd2);

    // Fill, then flush with a pending input.
    out_ready = 1'b0;
    drive(1'b1, 16'hCCCC, 5'd3, 3'b110);
    tick();
    drive(1'b1, 16'hDDDD, 5'd2, 3'b011);
    tick();
    chk("prefl_occ", 64'(occupancy), SKID ? 64'd2 : 64'd1);
    chk("prefl_exc", 64'(out_exc), 64'd3);
    chk("prefl_wren", 64'(out_wren), 64'd0);
    chk("prefl_stall", 64'(stall_cnt), 64'd3);
    flush = 1'b1;
    drive(1'b1, 16'hEEEE, 5'd0, 3'b111);
    tick();
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_payload", 64'(out_payload), 64'd0);
    chk("fl_exc", 64'(out_exc), 64'd0);
    chk("fl_wren", 64'(out_wren), 64'd0);
    chk("fl_stall", 64'(stall_cnt), 64'd4);
    flush = 1'b0;
    drive(1'b0, 16'h0000, 5'd0, 3'b000);
    tick();
    chk("postfl_valid", 64'(out_valid), 64'd0);
    chk("postfl_stall", 64'(stall_cnt), 64'd4);

    // Flush from EMPTY with in_valid and out_ready high: nothing captured.
    out_ready = 1'b1;
    flush     = 1'b1;
    drive(1'b1, 16'h9999, 5'd0, 3'b111);
    tick();
    chk("fle_valid", 64'(out_valid), 64'd0);
    chk("fle_payload", 64'(out_payload), 64'd0);
    flush = 1'b0;

    // Saturation: hold F for 2^CW+3 back-pressure cycles.
    out_ready = 1'b0;
    drive(1'b1, 16'hF00F, 5'd0, 3'b100);
    tick();
    drive(1'b0, 16'h0000, 5'd0, 3'b000);
    repeat ((1 << CW) + 3) tick();
    chk("sat_stall", 64'(stall_cnt), 64'hF);
    chk("sat_head", 64'(out_payload), 64'hF00F);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_fl_stall", 64'(stall_cnt), 64'hF);
    chk("sat_fl_occ", 64'(occupancy), 64'd0);

    // Asynchronous reset mid-stream.
    drive(1'b1, 16'h1111, 5'd0, 3'b001);
    tick();
    drive(1'b1, 16'h2222, 5'd0, 3'b010);
    tick();
    chk("prerst_occ", 64'(occupancy), SKID ? 64'd2 : 64'd1);
    drive(1'b0, 16'h0000, 5'd0, 3'b000);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_stall", 64'(stall_cnt), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_payload", 64'(out_payload), 64'd0);
    tick();
    #2 rst = 1'b1;
    tick();
    chk("rel2_valid", 64'(out_valid), 64'd0);
    chk("rel2_in_ready", 64'(in_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
